// File: rtl/adc_clk_pkg.sv
// -----------------------------------------------------------------------------
// adc_clk_pkg
// Shared constants for the ADC sample-clock generator and its command decoder.
//   RATE_*        half-period values (in 200 MHz system-clock cycles) for the
//                 supported sample rates; the generator defaults to RATE_20M.
//   rate_code_e   rate selector used by the command decoder.
//   rate_to_half  maps a rate code to the half-period the generator expects.
// -----------------------------------------------------------------------------
package adc_clk_pkg;

    localparam int unsigned RATE_1M  = 100;
    localparam int unsigned RATE_2M  = 50;
    localparam int unsigned RATE_5M  = 20;
    localparam int unsigned RATE_10M = 10;
    localparam int unsigned RATE_20M = 5;
    localparam int unsigned RATE_50M = 2;

    localparam int unsigned HALF_W = 16;

    typedef enum logic [2:0] {
        RC_1M  = 3'd0,
        RC_2M  = 3'd1,
        RC_5M  = 3'd2,
        RC_10M = 3'd3,
        RC_20M = 3'd4,
        RC_50M = 3'd5
    } rate_code_e;

    // Unknown codes fall back to the power-on rate so the decoder can never
    // request the illegal half-period of zero.
    function automatic logic [HALF_W-1:0] rate_to_half(input rate_code_e code);
        logic [HALF_W-1:0] half;
        case (code)
            RC_1M:   half = HALF_W'(RATE_1M);
            RC_2M:   half = HALF_W'(RATE_2M);
            RC_5M:   half = HALF_W'(RATE_5M);
            RC_10M:  half = HALF_W'(RATE_10M);
            RC_20M:  half = HALF_W'(RATE_20M);
            RC_50M:  half = HALF_W'(RATE_50M);
            default: half = HALF_W'(RATE_20M);
        endcase
        return half;
    endfunction

endpackage

// File: rtl/adc_clk_gen_mc_if.sv
// -----------------------------------------------------------------------------
// adc_clk_gen_mc_if
// Configuration bus between the command decoder (master) and the ADC clock
// generator (slave).
//   I_half_period  master->slave  requested half-period in system-clock cycles
//   I_cfg_valid    master->slave  one-cycle strobe qualifying the request
//   I_ch_enable    master->slave  requested per-channel clock enable
//   O_cfg_ack      slave->master  pulse when a pending request becomes active
//   O_cfg_err      slave->master  pulse when a request is rejected (half==0)
//   O_cfg_pending  slave->master  high while a request awaits a period boundary
// -----------------------------------------------------------------------------
interface adc_clk_gen_mc_if #(
    parameter int CNT_W = 16,
    parameter int N_CH  = 2
) ();

    logic [CNT_W-1:0] I_half_period;
    logic             I_cfg_valid;
    logic [N_CH-1:0]  I_ch_enable;
    logic             O_cfg_ack;
    logic             O_cfg_err;
    logic             O_cfg_pending;

    modport master (
        output I_half_period,
        output I_cfg_valid,
        output I_ch_enable,
        input  O_cfg_ack,
        input  O_cfg_err,
        input  O_cfg_pending
    );

    modport slave (
        input  I_half_period,
        input  I_cfg_valid,
        input  I_ch_enable,
        output O_cfg_ack,
        output O_cfg_err,
        output O_cfg_pending
    );

endinterface

// File: rtl/adc_dv_delay.sv
// -----------------------------------------------------------------------------
// adc_dv_delay
// Single-bit delay line of DEPTH registers used to align the data-valid strobe
// with the ADC pipeline latency.
//   I_clk    system clock
//   I_rst_n  asynchronous active-low reset, clears every stage
//   I_d      strobe in
//   O_q      strobe out, DEPTH cycles later
// -----------------------------------------------------------------------------
module adc_dv_delay #(
    parameter int DEPTH = 4
) (
    input  logic I_clk,
    input  logic I_rst_n,
    input  logic I_d,
    output logic O_q
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    generate
        if (DEPTH == 1) begin : g_single
            assign sr_d = I_d;
        end else begin : g_chain
            assign sr_d = {sr_q[DEPTH-2:0], I_d};
        end
    endgenerate

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign O_q = sr_q[DEPTH-1];

endmodule

// File: rtl/adc_clk_gen_mc.sv
// -----------------------------------------------------------------------------
// adc_clk_gen_mc
// Multi-channel ADC sample-clock generator. Divides I_clk by a runtime
// half-period, drives N_CH gated 50%-duty ADC clocks and per-channel
// data-valid strobes delayed to match the ADC pipeline. Rate and enable
// changes are held pending and applied only at a period boundary (end of a
// low phase), so no clock ever emits a shortened phase.
//   I_clk             system clock
//   I_rst_n           asynchronous active-low reset
//   cfg               configuration bus (slave side, see adc_clk_gen_mc_if)
//   O_adc_clk         gated ADC clocks, registered
//   O_adc_data_valid  one-cycle strobe per sample per enabled channel; fires
//                     DV_DELAY+1 cycles after the ADC clock first reads high
// -----------------------------------------------------------------------------
module adc_clk_gen_mc
    import adc_clk_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int N_CH     = 2,
    parameter int DEF_HALF = RATE_20M,
    parameter int DV_DELAY = 3
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    adc_clk_gen_mc_if.slave   cfg,
    output logic [N_CH-1:0]   O_adc_clk,
    output logic [N_CH-1:0]   O_adc_data_valid
);

    // Phase generator and active configuration
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ph_q, ph_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [N_CH-1:0]  en_q, en_d;

    // Configuration waiting for the next period boundary
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] pend_half_q, pend_half_d;
    logic [N_CH-1:0]  pend_en_q, pend_en_d;

    // Registered outputs
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [N_CH-1:0]  clk_q, clk_d;
    logic             rise_q, rise_d;

    logic [CNT_W-1:0] half_m1;
    logic             at_end;
    logic             boundary;

    // half is never zero (rejected at the config port), so half-1 cannot wrap.
    assign half_m1  = half_q - CNT_W'(1);
    assign at_end   = (cnt_q == half_m1);
    assign boundary = at_end & ~ph_q;

    always_comb begin
        cnt_d       = cnt_q;
        ph_d        = ph_q;
        half_d      = half_q;
        en_d        = en_q;
        pend_d      = pend_q;
        pend_half_d = pend_half_q;
        pend_en_d   = pend_en_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;

        if (boundary && pend_q) begin
            // New rate starts with a full high phase.
            half_d = pend_half_q;
            en_d   = pend_en_q;
            cnt_d  = '0;
            ph_d   = 1'b1;
            ack_d  = 1'b1;
            pend_d = 1'b0;
        end else if (at_end) begin
            cnt_d = '0;
            ph_d  = ~ph_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Evaluated after the boundary transfer: a request arriving on the
        // boundary cycle itself is held for the following boundary, and a
        // later request simply overwrites an earlier one still waiting.
        if (cfg.I_cfg_valid) begin
            if (cfg.I_half_period != '0) begin
                pend_d      = 1'b1;
                pend_half_d = cfg.I_half_period;
                pend_en_d   = cfg.I_ch_enable;
            end else begin
                err_d = 1'b1;
            end
        end

        // Registered copy of the gated phase, so O_adc_clk tracks ph_q exactly.
        clk_d  = {N_CH{ph_d}} & en_d;
        rise_d = ph_d & ~ph_q;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cnt_q       <= '0;
            ph_q        <= 1'b0;
            half_q      <= CNT_W'(DEF_HALF);
            en_q        <= '1;
            pend_q      <= 1'b0;
            pend_half_q <= '0;
            pend_en_q   <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            clk_q       <= '0;
            rise_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            ph_q        <= ph_d;
            half_q      <= half_d;
            en_q        <= en_d;
            pend_q      <= pend_d;
            pend_half_q <= pend_half_d;
            pend_en_q   <= pend_en_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            clk_q       <= clk_d;
            rise_q      <= rise_d;
        end
    end

    // rise_q is high on the first cycle the clock reads 1; the extra delay
    // stage doubles as the output register. Because each channel uses a plain
    // shift register, overlapping pulses at fast rates never merge or drop,
    // and pulses already in flight finish after the channel is disabled.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_dv
            adc_dv_delay #(
                .DEPTH (DV_DELAY + 1)
            ) u_dv_delay (
                .I_clk   (I_clk),
                .I_rst_n (I_rst_n),
                .I_d     (rise_q & en_q[gi]),
                .O_q     (O_adc_data_valid[gi])
            );
        end
    endgenerate

    assign O_adc_clk         = clk_q;
    assign cfg.O_cfg_ack     = ack_q;
    assign cfg.O_cfg_err     = err_q;
    assign cfg.O_cfg_pending = pend_q;

endmodule

// File: tb/tb_adc_clk_gen_mc.sv
// -----------------------------------------------------------------------------
// tb_adc_clk_gen_mc
// Directed scenarios followed by a randomized configuration stream. Expected
// outputs come from a cycle-indexed reference: the clock phase is computed
// arithmetically from the start of the current rate segment, and data-valid
// pulses are scheduled in a small time-slot table.
// -----------------------------------------------------------------------------
module tb_adc_clk_gen_mc;

    localparam int CNT_W    = 16;
    localparam int N_CH     = 2;
    localparam int DEF_HALF = 5;
    localparam int DVD      = 3;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] adc_clk;
    logic [N_CH-1:0] adc_dv;

    adc_clk_gen_mc_if #(.CNT_W(CNT_W), .N_CH(N_CH)) cfg_if ();

    adc_clk_gen_mc #(
        .CNT_W    (CNT_W),
        .N_CH     (N_CH),
        .DEF_HALF (DEF_HALF),
        .DV_DELAY (DVD)
    ) dut (
        .I_clk            (clk),
        .I_rst_n          (rst_n),
        .cfg              (cfg_if),
        .O_adc_clk        (adc_clk),
        .O_adc_data_valid (adc_dv)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    int              m_n;          // cycles since reset release
    int              m_s;          // cycle at which current rate segment began
    bit              m_p0;         // phase at segment start
    int              m_half;
    logic [N_CH-1:0] m_en;
    bit              m_pend;
    int              m_pend_half;
    logic [N_CH-1:0] m_pend_en;
    bit              m_ack;
    bit              m_err;
    logic [N_CH-1:0] m_dv [16];

    function automatic bit ph_at(input int c);
        return m_p0 ^ bit'(((c - m_s) / m_half) % 2);
    endfunction

    task automatic model_reset();
        m_n = 0; m_s = 0; m_p0 = 1'b0; m_half = DEF_HALF; m_en = '1;
        m_pend = 1'b0; m_pend_half = 0; m_pend_en = '0;
        m_ack = 1'b0; m_err = 1'b0;
        for (int i = 0; i < 16; i++) m_dv[i] = '0;
    endtask

    task automatic model_advance(input bit vld, input int hp, input logic [N_CH-1:0] en);
        bit cur;
        bit nxt;
        bit bnd;
        cur   = ph_at(m_n);
        bnd   = !cur && (((m_n - m_s + 1) % m_half) == 0);
        m_ack = bnd && m_pend;
        if (m_ack) begin
            m_half = m_pend_half;
            m_en   = m_pend_en;
            m_s    = m_n + 1;
            m_p0   = 1'b1;
            m_pend = 1'b0;
        end
        m_err = vld && (hp == 0);
        if (vld && hp != 0) begin
            m_pend      = 1'b1;
            m_pend_half = hp;
            m_pend_en   = en;
        end
        m_dv[m_n % 16] = '0;
        m_n++;
        nxt = ph_at(m_n);
        if (nxt && !cur) m_dv[(m_n + DVD + 1) % 16] = m_dv[(m_n + DVD + 1) % 16] | m_en;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, m_n, got, exp);
        end
    endtask

    task automatic check_outputs();
        bit ph;
        ph = ph_at(m_n);
        chk("adc_clk", 32'(adc_clk), 32'({N_CH{ph}} & m_en));
        chk("adc_dv",  32'(adc_dv),  32'(m_dv[m_n % 16]));
        chk("cfg_ack", 32'(cfg_if.O_cfg_ack), 32'(m_ack));
        chk("cfg_err", 32'(cfg_if.O_cfg_err), 32'(m_err));
        chk("cfg_pend", 32'(cfg_if.O_cfg_pending), 32'(m_pend));
    endtask

    // One clock cycle: drive inputs (caller sits at a negedge), advance the
    // model at the posedge, compare at the following negedge.
    task automatic tick(input bit vld, input int hp, input logic [N_CH-1:0] en);
        cfg_if.I_cfg_valid   = vld;
        cfg_if.I_half_period = CNT_W'(hp);
        cfg_if.I_ch_enable   = en;
        if (vld) $display("cycle %0d: cfg half=%0d en=%b", m_n, hp, en);
        @(posedge clk);
        model_advance(vld, hp, en);
        @(negedge clk);
        cfg_if.I_cfg_valid = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick(1'b0, 0, '0);
    endtask

    // Reset asserted mid-operation must clear outputs immediately.
    task automatic do_reset();
        $display("cycle %0d: reset asserted", m_n);
        rst_n = 1'b0;
        #1;
        chk("rst_clk",  32'(adc_clk), 32'(0));
        chk("rst_dv",   32'(adc_dv), 32'(0));
        chk("rst_ack",  32'(cfg_if.O_cfg_ack), 32'(0));
        chk("rst_err",  32'(cfg_if.O_cfg_err), 32'(0));
        chk("rst_pend", 32'(cfg_if.O_cfg_pending), 32'(0));
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
    endtask

    initial begin
        int hp;
        logic [N_CH-1:0] en;

        cfg_if.I_cfg_valid   = 1'b0;
        cfg_if.I_half_period = '0;
        cfg_if.I_ch_enable   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        check_outputs();

        // Default rate after reset, both channels running.
        idle(40);

        // Switch to half=1 from inside a high phase.
        for (int i = 0; i < 20 && !(ph_at(m_n) && ((m_n - m_s) % m_half) == 1); i++) idle(1);
        tick(1'b1, 1, 2'b11);
        idle(30);

        // Illegal half-period is rejected.
        tick(1'b1, 0, 2'b11);
        idle(20);

        // Back to the default rate, then two enable requests back to back.
        tick(1'b1, 5, 2'b11);
        idle(30);
        for (int i = 0; i < 20 && !(ph_at(m_n) && ((m_n - m_s) % m_half) == 1); i++) idle(1);
        tick(1'b1, 5, 2'b01);
        tick(1'b1, 5, 2'b10);
        idle(40);

        // Pending slow-rate request discarded by a reset.
        tick(1'b1, 50, 2'b11);
        idle(7);
        do_reset();
        idle(30);

        // Randomized configuration stream.
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 2999) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 19))
                    0:           hp = 0;
                    1, 2, 3, 4:  hp = int'($urandom_range(13, 200));
                    default:     hp = int'($urandom_range(1, 12));
                endcase
                en = N_CH'($urandom);
                tick(1'b1, hp, en);
            end else begin
                idle(1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
